// File: rtl/ej32_ls_if.sv
// Load/store request and byte-wide memory bus bundle for the eJ32 sequencer.
// master = control/AU stage plus memory side, slave = the sequencer itself.
interface ej32_ls_if #(
    parameter int DSZ = 32,
    parameter int ASZ = 17
) ();
    // request side
    logic           req;
    logic           we;
    logic [1:0]     sz;
    logic           sext;
    logic [ASZ-1:0] addr;
    logic [DSZ-1:0] wdata;
    logic           bsy;
    logic           done;
    logic           err;
    logic [DSZ-1:0] rdata;
    // byte-wide memory side
    logic [ASZ-1:0] mem_a;
    logic           mem_en;
    logic           mem_we;
    logic [7:0]     mem_wd;
    logic [7:0]     mem_rd;
    logic           mem_rdy;

    modport master (
        output req, we, sz, sext, addr, wdata,
        input  bsy, done, err, rdata,
        input  mem_a, mem_en, mem_we, mem_wd,
        output mem_rd, mem_rdy
    );

    modport slave (
        input  req, we, sz, sext, addr, wdata,
        output bsy, done, err, rdata,
        output mem_a, mem_en, mem_we, mem_wd,
        input  mem_rd, mem_rdy
    );
endinterface

// File: rtl/ej32_ls.sv
// eJ32 load/store sequencer: breaks one byte/short/int access into
// big-endian single-byte transfers on an 8-bit memory bus, assembling
// and extending load data, and slicing store data MSB first.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for req; request is checked for size/alignment here
// XFER   | one byte per mem_rdy cycle, k counts bytes already moved
// DONE   | one-cycle done pulse (err set if the request was rejected)
module ej32_ls #(
    parameter int DSZ = 32,
    parameter int ASZ = 17
) (
    input  logic         clk,
    input  logic         rst,
    ej32_ls_if.slave     bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]     state;
    logic [1:0]     state_nx;

    logic           we_l;
    logic           sext_l;
    logic           err_l;
    logic [1:0]     sz_l;
    logic [ASZ-1:0] addr_l;
    logic [DSZ-1:0] wdata_l;
    logic [DSZ-1:0] rdata_r;
    // only the bytes before the final one need storing; the last byte
    // comes straight off mem_rd when the result is formed
    logic [DSZ-9:0] acc;
    logic [1:0]     k;

    logic           reject;
    logic [1:0]     last_k;
    logic           beat;
    logic           last_beat;
    logic [1:0]     byte_sel;
    logic [7:0]     wbyte;
    logic [DSZ-1:0] load_val;

    // size 3 is reserved; shorts need even, ints need word alignment
    always_comb begin
        reject = 1'b0;
        case (bus.sz)
            2'd0:    reject = 1'b0;
            2'd1:    reject = bus.addr[0];
            2'd2:    reject = (bus.addr[1:0] != 2'b00);
            default: reject = 1'b1;
        endcase
    end

    // index of the final byte: byte 0, short 1, int 3
    assign last_k    = {sz_l[1], sz_l[1] | sz_l[0]};
    assign beat      = (state == S_XFER) && bus.mem_rdy;
    assign last_beat = beat && (k == last_k);

    // store data goes out most significant byte first
    assign byte_sel = last_k - k;

    // pick the store byte for the current position
    always_comb begin
        wbyte = 8'h00;
        case (byte_sel)
            2'd0:    wbyte = wdata_l[7:0];
            2'd1:    wbyte = wdata_l[15:8];
            2'd2:    wbyte = wdata_l[23:16];
            default: wbyte = wdata_l[31:24];
        endcase
    end

    // final load result: accumulated bytes plus the byte arriving now
    always_comb begin
        load_val = '0;
        case (sz_l)
            2'd0:    load_val = {{(DSZ-8){sext_l & bus.mem_rd[7]}}, bus.mem_rd};
            2'd1:    load_val = {{(DSZ-16){sext_l & acc[7]}}, acc[7:0], bus.mem_rd};
            default: load_val = {acc, bus.mem_rd};
        endcase
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (bus.req) begin
                    state_nx = reject ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (last_beat) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // state register, request latches, byte counter and load assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            we_l    <= 1'b0;
            sext_l  <= 1'b0;
            err_l   <= 1'b0;
            sz_l    <= 2'd0;
            addr_l  <= '0;
            wdata_l <= '0;
            acc     <= '0;
            k       <= 2'd0;
            rdata_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: begin
                    if (bus.req) begin
                        if (reject) begin
                            err_l <= 1'b1;
                        end else begin
                            err_l   <= 1'b0;
                            we_l    <= bus.we;
                            sz_l    <= bus.sz;
                            sext_l  <= bus.sext;
                            addr_l  <= bus.addr;
                            wdata_l <= bus.wdata;
                            acc     <= '0;
                            k       <= 2'd0;
                        end
                    end
                end
                S_XFER: begin
                    if (beat) begin
                        if (!we_l) begin
                            acc <= {acc[DSZ-17:0], bus.mem_rd};
                        end
                        if (last_beat) begin
                            k <= 2'd0;
                            if (!we_l) begin
                                rdata_r <= load_val;
                            end
                        end else begin
                            k <= k + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs decode purely from state so they are quiet outside XFER
    always_comb begin
        bus.bsy    = (state != S_IDLE);
        bus.done   = (state == S_DONE);
        bus.err    = (state == S_DONE) && err_l;
        bus.rdata  = rdata_r;
        bus.mem_en = (state == S_XFER);
        bus.mem_we = (state == S_XFER) && we_l;
        bus.mem_a  = '0;
        bus.mem_wd = 8'h00;
        if (state == S_XFER) begin
            bus.mem_a = addr_l + {{(ASZ-2){1'b0}}, k};
        end
        if ((state == S_XFER) && we_l) begin
            bus.mem_wd = wbyte;
        end
    end

endmodule

// File: tb/tb_ej32_ls.sv
// Directed bench for the eJ32 load/store sequencer: a byte-addressed
// memory model, a vector table of single transactions, and hand-written
// sequences for wait states and mid-transfer reset.
module tb_ej32_ls;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ej32_ls_if #(.DSZ(32), .ASZ(17)) lif ();

    ej32_ls #(.DSZ(32), .ASZ(17)) dut (
        .clk (clk),
        .rst (rst),
        .bus (lif)
    );

    // memory model
    logic [7:0]  mem [0:131071];
    logic        pl_en = 1'b0;
    logic [16:0] pl_a  = '0;
    logic [7:0]  pl_d  = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (lif.mem_en && lif.mem_we && lif.mem_rdy)
            mem[lif.mem_a] <= lif.mem_wd;
    end

    assign lif.mem_rd = mem[lif.mem_a];

    int n_pass = 0;
    int n_tot  = 0;
    int viol   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // bus rules that must hold on every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            if (lif.mem_we && !lif.mem_en) viol++;
            if (!lif.mem_we && lif.mem_wd != 8'h00) viol++;
            if (lif.err && !lif.done) viol++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        @(posedge clk); #1;
        pl_en = 1'b0;
    endtask

    // results of the last run_txn
    int          r_lat, r_en, r_we, r_bsy;
    logic        r_err;
    logic [31:0] r_rdata;
    logic [16:0] r_afirst, r_alast;
    logic [7:0]  r_wd0;

    // issue one request at the current cycle and watch until done
    task automatic run_txn(input logic we, input logic [1:0] sz, input logic sext,
                           input logic [16:0] addr, input logic [31:0] wdata);
        logic seen_en, seen_wd;
        seen_en = 1'b0; seen_wd = 1'b0;
        r_lat = 0; r_en = 0; r_we = 0; r_bsy = 0;
        r_err = 1'b0; r_rdata = '0; r_afirst = '0; r_alast = '0; r_wd0 = '0;
        lif.req = 1'b1; lif.we = we; lif.sz = sz; lif.sext = sext;
        lif.addr = addr; lif.wdata = wdata;
        @(posedge clk); #1;
        lif.req = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            if (lif.mem_en) begin
                r_en++;
                r_alast = lif.mem_a;
                if (!seen_en) begin r_afirst = lif.mem_a; seen_en = 1'b1; end
            end
            if (lif.mem_we) begin
                r_we++;
                if (!seen_wd) begin r_wd0 = lif.mem_wd; seen_wd = 1'b1; end
            end
            if (lif.bsy) r_bsy++;
            if (lif.done) begin
                r_lat = cyc; r_err = lif.err; r_rdata = lif.rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  sz;
        logic        sext;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [16:0] exp_alast;
        logic [7:0]  exp_wd0;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int n_exp, done_cnt, done_cyc;
        logic [31:0] rd;

        vecs[0]  = '{1'b0, 2'd2, 1'b0, 17'h00100, 32'h0,        32'h12345678, 1'b0, 5, 17'h00103, 8'h00};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 17'h00300, 32'h0,        32'hFFFFFF80, 1'b0, 2, 17'h00300, 8'h00};
        vecs[2]  = '{1'b0, 2'd0, 1'b0, 17'h00300, 32'h0,        32'h00000080, 1'b0, 2, 17'h00300, 8'h00};
        vecs[3]  = '{1'b0, 2'd1, 1'b1, 17'h00302, 32'h0,        32'hFFFFFFFE, 1'b0, 3, 17'h00303, 8'h00};
        vecs[4]  = '{1'b0, 2'd1, 1'b0, 17'h00302, 32'h0,        32'h0000FFFE, 1'b0, 3, 17'h00303, 8'h00};
        vecs[5]  = '{1'b1, 2'd2, 1'b0, 17'h00200, 32'hDEADBEEF, 32'h0000FFFE, 1'b0, 5, 17'h00203, 8'hDE};
        vecs[6]  = '{1'b0, 2'd2, 1'b0, 17'h00200, 32'h0,        32'hDEADBEEF, 1'b0, 5, 17'h00203, 8'h00};
        vecs[7]  = '{1'b1, 2'd1, 1'b0, 17'h00210, 32'h1234ABCD, 32'hDEADBEEF, 1'b0, 3, 17'h00211, 8'hAB};
        vecs[8]  = '{1'b0, 2'd1, 1'b1, 17'h00210, 32'h0,        32'hFFFFABCD, 1'b0, 3, 17'h00211, 8'h00};
        vecs[9]  = '{1'b1, 2'd0, 1'b0, 17'h00215, 32'h00000077, 32'hFFFFABCD, 1'b0, 2, 17'h00215, 8'h77};
        vecs[10] = '{1'b0, 2'd0, 1'b1, 17'h00215, 32'h0,        32'h00000077, 1'b0, 2, 17'h00215, 8'h00};
        vecs[11] = '{1'b0, 2'd2, 1'b0, 17'h00102, 32'h0,        32'h00000077, 1'b1, 1, 17'h00000, 8'h00};
        vecs[12] = '{1'b1, 2'd3, 1'b0, 17'h00100, 32'h55555555, 32'h00000077, 1'b1, 1, 17'h00000, 8'h00};
        vecs[13] = '{1'b0, 2'd1, 1'b0, 17'h00101, 32'h0,        32'h00000077, 1'b1, 1, 17'h00000, 8'h00};
        vecs[14] = '{1'b0, 2'd1, 1'b0, 17'h1FFFE, 32'h0,        32'h0000A55A, 1'b0, 3, 17'h1FFFF, 8'h00};

        lif.req = 1'b0; lif.we = 1'b0; lif.sz = 2'd0; lif.sext = 1'b0;
        lif.addr = '0; lif.wdata = '0; lif.mem_rdy = 1'b1;

        // memory image loaded while the sequencer is held in reset
        @(posedge clk); #1;
        preload(17'h00100, 8'h12); preload(17'h00101, 8'h34);
        preload(17'h00102, 8'h56); preload(17'h00103, 8'h78);
        preload(17'h00300, 8'h80); preload(17'h00302, 8'hFF);
        preload(17'h00303, 8'hFE); preload(17'h1FFFE, 8'hA5);
        preload(17'h1FFFF, 8'h5A); preload(17'h00000, 8'h00);
        for (int i = 0; i < 4; i++) preload(17'h00200 + 17'(i), 8'h00);
        for (int i = 0; i < 8; i++) preload(17'h00210 + 17'(i), 8'h00);
        for (int i = 0; i < 4; i++) preload(17'h00220 + 17'(i), 8'h00);

        @(negedge clk);
        chk("reset_flags", {27'd0, lif.bsy, lif.done, lif.err, lif.mem_en, lif.mem_we}, 32'd0);
        chk("reset_rdata", lif.rdata, 32'd0);
        chk("reset_bus", {7'd0, lif.mem_a, lif.mem_wd}, 32'd0);

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            run_txn(vecs[i].we, vecs[i].sz, vecs[i].sext, vecs[i].addr, vecs[i].wdata);
            n_exp = vecs[i].exp_err ? 0 : vecs[i].exp_lat - 1;
            chk($sformatf("v%0d_latency", i), r_lat, vecs[i].exp_lat);
            chk($sformatf("v%0d_err", i), {31'd0, r_err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("v%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_mem_en_cycles", i), r_en, n_exp);
            chk($sformatf("v%0d_mem_we_cycles", i), r_we, vecs[i].we ? n_exp : 0);
            chk($sformatf("v%0d_bsy_cycles", i), r_bsy, vecs[i].exp_lat);
            if (n_exp > 0) begin
                chk($sformatf("v%0d_first_addr", i), {15'd0, r_afirst}, {15'd0, vecs[i].addr});
                chk($sformatf("v%0d_last_addr", i), {15'd0, r_alast}, {15'd0, vecs[i].exp_alast});
            end
            if (vecs[i].we && !vecs[i].exp_err)
                chk($sformatf("v%0d_first_wbyte", i), {24'd0, r_wd0}, {24'd0, vecs[i].exp_wd0});
        end

        // wait states on the second byte of an int load, req pulsed mid-transfer
        lif.req = 1'b1; lif.we = 1'b0; lif.sz = 2'd2; lif.sext = 1'b0;
        lif.addr = 17'h00100; lif.wdata = '0;
        @(posedge clk); #1;
        lif.req = 1'b0;
        @(negedge clk);
        chk("stall_byte0_addr", {15'd0, lif.mem_a}, 32'h00000100);
        @(posedge clk); #1;
        lif.mem_rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) begin
                lif.req = 1'b1; lif.we = 1'b1; lif.sz = 2'd0;
                lif.addr = 17'h00000; lif.wdata = 32'h000000FF;
            end
            @(negedge clk);
            chk($sformatf("stall%0d_addr", s), {15'd0, lif.mem_a}, 32'h00000101);
            chk($sformatf("stall%0d_en_no_done", s), {30'd0, lif.mem_en, lif.done}, 32'd2);
            @(posedge clk); #1;
            lif.req = 1'b0; lif.we = 1'b0;
        end
        lif.mem_rdy = 1'b1;
        done_cyc = 0; rd = '0;
        for (int c = 5; c < 30; c++) begin
            @(negedge clk);
            if (lif.done) begin done_cyc = c; rd = lif.rdata; break; end
            @(posedge clk); #1;
        end
        chk("stall_done_cycle", done_cyc, 8);
        chk("stall_rdata", rd, 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        chk("stall_no_queued_req", {30'd0, lif.bsy, lif.mem_en}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stall_ignored_store", {24'd0, mem[0]}, 32'd0);

        // reset in the middle of an int store
        lif.req = 1'b1; lif.we = 1'b1; lif.sz = 2'd2;
        lif.addr = 17'h00220; lif.wdata = 32'h11223344;
        @(posedge clk); #1;
        lif.req = 1'b0; lif.we = 1'b0;
        @(negedge clk);
        chk("rst_pre_wd", {24'd0, lif.mem_wd}, 32'h00000011);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_pre_addr", {15'd0, lif.mem_a}, 32'h00000221);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_flags", {27'd0, lif.bsy, lif.mem_en, lif.mem_we, lif.done, lif.err}, 32'd0);
        chk("rst_rdata", lif.rdata, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (lif.done) done_cnt++;
        end
        chk("rst_no_done", done_cnt, 0);
        chk("rst_byte2_untouched", {24'd0, mem[17'h00222]}, 32'd0);
        @(posedge clk); #1;

        // sequencer recovers after the abandoned transfer
        run_txn(1'b0, 2'd0, 1'b1, 17'h00300, 32'h0);
        chk("recover_latency", r_lat, 2);
        chk("recover_rdata", r_rdata, 32'hFFFFFF80);

        chk("bus_rules", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
